// File: rtl/pixel_stream_source.sv
// Frame pixel stream generator: emits frame_len pixels of a test pattern over valid/ready.
// Optional LFSR pattern generator compiled in with `define PIXSRC_LFSR_EN; otherwise pattern 11 acts as ramp.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for start, outputs hold last frame info
// ST_SEND   | m_valid high, advancing pattern on each transfer
// ST_DONE   | single-cycle done pulse, then back to idle
module pixel_stream_source #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic [1:0]       pattern,
    input  logic [WIDTH-1:0] seed,
    input  logic [1:0]       mode_cfg,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       m_mode,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pix_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] PAT_CONST = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd2;
`ifdef PIXSRC_LFSR_EN
    localparam logic [1:0] PAT_LFSR  = 2'd3;
    localparam logic [WIDTH-1:0] LFSR_MASK = WIDTH'(8'hB8);
`endif

    localparam logic [WIDTH-1:0] PIX_ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [1:0]       pat_q, pat_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;

`ifdef PIXSRC_LFSR_EN
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] s;
        s = cur >> 1;
        if (cur[0]) s = s ^ LFSR_MASK;
        return s;
    endfunction
`endif

    function automatic logic [WIDTH-1:0] first_pix(input logic [1:0] pat,
                                                   input logic [WIDTH-1:0] sd);
        logic [WIDTH-1:0] v;
        v = sd;
`ifdef PIXSRC_LFSR_EN
        // An all-zero LFSR would lock up, so a zero seed starts at 1.
        if (pat == PAT_LFSR && sd == '0) v = PIX_ONE;
`else
        if (pat == PAT_CONST) v = sd;
`endif
        return v;
    endfunction

    // Every pattern's next value is derivable from the current pixel alone.
    function automatic logic [WIDTH-1:0] next_pix(input logic [1:0] pat,
                                                  input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] v;
        case (pat)
            PAT_CONST: v = cur;
            PAT_CHECK: v = ~cur;
`ifdef PIXSRC_LFSR_EN
            PAT_LFSR:  v = lfsr_step(cur);
`endif
            default:   v = cur + PIX_ONE;
        endcase
        return v;
    endfunction

    assign xfer = valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pat_d   = pat_q;
        mode_d  = mode_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (frame_len != '0) begin
                        state_d = ST_SEND;
                        len_d   = frame_len;
                        pat_d   = pattern;
                        mode_d  = mode_cfg;
                        data_d  = first_pix(pattern, seed);
                        valid_d = 1'b1;
                        last_d  = (frame_len == CNT_ONE);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    cnt_d  = cnt_q + CNT_ONE;
                    data_d = next_pix(pat_q, data_q);
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        last_d = (cnt_d == (len_q - CNT_ONE));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            pat_q   <= '0;
            mode_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_valid   = valid_q;
    assign m_data    = data_q;
    assign m_mode    = mode_q;
    assign m_last    = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_count = cnt_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench for pixel_stream_source: expected pixels are queued at start and
// consumed on each accepted transfer; frame timing and control outputs are checked inline.
module tb_pixel_stream_source;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] frame_len;
    logic [1:0]       pattern;
    logic [WIDTH-1:0] seed;
    logic [1:0]       mode_cfg;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       m_mode;
    logic             m_last;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pix_count;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [1:0]       exp_mode = 2'd0;

    always #5 clk = ~clk;

    pixel_stream_source #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .pattern(pattern), .seed(seed), .mode_cfg(mode_cfg),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_mode(m_mode),
        .m_last(m_last), .busy(busy), .done(done), .pix_count(pix_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_model(input logic [7:0] v);
        logic [7:0] s;
        s = {1'b0, v[7:1]};
        if (v[0]) s = s ^ 8'hB8;
        return s;
    endfunction

    // Monitor: sampled on the falling edge, so the values seen are those the next rising edge uses.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (m_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(m_valid), 32'd0);
            end else begin
                chk("m_data", 32'(m_data), 32'(exp_q[0]));
                chk("m_last", 32'(m_last), 32'(exp_q.size() == 1));
                chk("m_mode", 32'(m_mode), 32'(exp_mode));
                if (m_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    acc_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len, input logic [1:0] pat, input logic [7:0] sd,
                               input logic [1:0] md);
        logic [7:0] lv;
        logic [7:0] val;
        frame_len = CNT_W'(len);
        pattern   = pat;
        seed      = sd;
        mode_cfg  = md;
        exp_mode  = md;
        lv = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < len; i++) begin
            case (pat)
                2'd0: val = sd;
                2'd2: val = (i % 2 == 1) ? ~sd : sd;
`ifdef PIXSRC_LFSR_EN
                2'd3: begin
                    val = lv;
                    lv  = lfsr_model(lv);
                end
`endif
                default: val = sd + 8'(i);
            endcase
            exp_q.push_back(val);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int a0;
        logic rp[6];
        rp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        frame_len = '0;
        pattern = 2'd0;
        seed = '0;
        mode_cfg = 2'd0;
        #2;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_mode", 32'(m_mode), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(pix_count), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ramp with wrap, full throughput
        m_ready = 1'b1;
        start_frame(4, 2'd1, 8'hFE, 2'd1);
        chk("ramp_valid_after_start", 32'(m_valid), 32'd1);
        chk("ramp_busy_after_start", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("ramp_no_early_done", 32'(done), 32'd0);
        chk("ramp_valid_mid", 32'(m_valid), 32'd1);
        tick();
        chk("ramp_done", 32'(done), 32'd1);
        chk("ramp_valid_end", 32'(m_valid), 32'd0);
        chk("ramp_last_end", 32'(m_last), 32'd0);
        chk("ramp_busy_done", 32'(busy), 32'd1);
        chk("ramp_cnt", 32'(pix_count), 32'd4);
        tick();
        chk("ramp_done_one_cycle", 32'(done), 32'd0);
        chk("ramp_busy_low", 32'(busy), 32'd0);
        chk("ramp_cnt_hold", 32'(pix_count), 32'd4);
        chk("ramp_q_empty", 32'(exp_q.size()), 32'd0);

        // checker under backpressure
        m_ready = 1'b0;
        a0 = acc_cnt;
        start_frame(3, 2'd2, 8'h0F, 2'd0);
        for (int i = 0; i < 6; i++) begin
            m_ready = rp[i];
            tick();
        end
        wait_done("bp_done");
        chk("bp_accepted", 32'(acc_cnt - a0), 32'd3);
        chk("bp_cnt", 32'(pix_count), 32'd3);
        chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
        tick();
        chk("bp_busy_low", 32'(busy), 32'd0);

        // zero-length frame
        start_frame(0, 2'd1, 8'h00, 2'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_valid", 32'(m_valid), 32'd0);
        chk("zero_cnt", 32'(pix_count), 32'd0);
        tick();
        chk("zero_done_off", 32'(done), 32'd0);
        chk("zero_busy_off", 32'(busy), 32'd0);
        chk("zero_valid_off", 32'(m_valid), 32'd0);

        // start while busy is ignored
        d0 = done_cnt;
        start_frame(5, 2'd0, 8'h55, 2'd2);
        tick();
        seed = 8'hAA;
        frame_len = CNT_W'(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("sb_done");
        repeat (3) tick();
        chk("sb_single_done", 32'(done_cnt - d0), 32'd1);
        chk("sb_cnt", 32'(pix_count), 32'd5);
        chk("sb_busy_low", 32'(busy), 32'd0);
        chk("sb_q_empty", 32'(exp_q.size()), 32'd0);

        // reset mid-frame, then a normal frame
        a0 = acc_cnt;
        d0 = done_cnt;
        start_frame(6, 2'd1, 8'h10, 2'd3);
        tick();
        tick();
        chk("rm_two_xfers", 32'(acc_cnt - a0), 32'd2);
        rst = 1'b0;
        #1;
        chk("rm_valid", 32'(m_valid), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_cnt", 32'(pix_count), 32'd0);
        chk("rm_data", 32'(m_data), 32'd0);
        chk("rm_mode", 32'(m_mode), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("rm_no_done", 32'(done_cnt - d0), 32'd0);
        start_frame(3, 2'd1, 8'h20, 2'd1);
        wait_done("rm_fresh_done");
        chk("rm_fresh_cnt", 32'(pix_count), 32'd3);
        chk("rm_fresh_q_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // pattern 11 with zero seed: LFSR when compiled in, ramp otherwise
        start_frame(3, 2'd3, 8'h00, 2'd0);
        wait_done("lfsr_done");
        tick();
        chk("lfsr_cnt", 32'(pix_count), 32'd3);
        chk("lfsr_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
